// File: rtl/core_mem_arbiter.sv
// Shares one downstream dcache/memory port among NUM_REQ core request ports,
// one transaction at a time, with round-robin or fixed-priority selection.
module core_mem_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
  input  logic [NUM_REQ-1:0]          req_we_i,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_sel_i,
  output logic [NUM_REQ-1:0]          req_ack_o,
  output logic [DATA_W-1:0]           req_rdata_o,
  output logic                        mem_req_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  output logic                        mem_we_o,
  output logic [DATA_W/8-1:0]         mem_sel_o,
  input  logic                        mem_ack_i,
  input  logic [DATA_W-1:0]           mem_rdata_i,
  input  logic                        flush_i,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id_o,
  output logic                        busy_o
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int SEL_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_grant;
  logic [NUM_REQ-1:0]  r_ack;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_mem_req;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_we;
  logic [SEL_W-1:0]    r_sel;
  logic                r_busy;

  logic [ADDR_W-1:0]   w_addr  [NUM_REQ];
  logic [DATA_W-1:0]   w_wdata [NUM_REQ];
  logic                w_we    [NUM_REQ];
  logic [SEL_W-1:0]    w_sel   [NUM_REQ];
  logic [ID_W-1:0]     w_start;
  logic [ID_W-1:0]     w_win_id;
  logic                w_win_vld;
  logic [ID_W-1:0]     w_ptr_nxt;
  logic [NUM_REQ-1:0]  w_ack_hot;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign w_addr[k]  = req_addr_i[k*ADDR_W +: ADDR_W];
    assign w_wdata[k] = req_wdata_i[k*DATA_W +: DATA_W];
    assign w_we[k]    = req_we_i[k];
    assign w_sel[k]   = req_sel_i[k*SEL_W +: SEL_W];
  end

  // First set valid bit found scanning upward from start with wrap; MSB flags a hit.
  function automatic logic [ID_W:0] f_pick(input logic [NUM_REQ-1:0] valid,
                                           input logic [ID_W-1:0]    start);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] idx;
    res = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(start) + i) % NUM_REQ);
      res = (valid[idx] && !res[ID_W]) ? {1'b1, idx} : res;
    end
    return res;
  endfunction

  // Fixed priority always scans from index 0 so the lowest live index wins.
  always_comb begin
    w_start               = (ARB_MODE == 1) ? '0 : r_ptr;
    {w_win_vld, w_win_id} = f_pick(req_valid_i, w_start);
    w_ptr_nxt             = ID_W'((int'(w_win_id) + 1) % NUM_REQ);
    w_ack_hot             = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant;
  end

  // Grant/serve/respond sequencer; request contents are captured only at grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_grant   <= '0;
      r_ack     <= '0;
      r_rdata   <= '0;
      r_mem_req <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack <= '0;
          if (w_win_vld && !flush_i) begin
            r_addr    <= w_addr[w_win_id];
            r_wdata   <= w_wdata[w_win_id];
            r_we      <= w_we[w_win_id];
            r_sel     <= w_sel[w_win_id];
            r_grant   <= w_win_id;
            r_ptr     <= (ARB_MODE == 0) ? w_ptr_nxt : r_ptr;
            r_mem_req <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mem_ack_i) begin
            r_rdata   <= mem_rdata_i;
            r_ack     <= w_ack_hot;
            r_mem_req <= 1'b0;
            r_state   <= ST_RESP;
          end
        end
        // One dead cycle lets the acked requestor drop its valid before re-arbitration.
        ST_RESP: begin
          r_ack   <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ack     <= '0;
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ack_o   = r_ack;
  assign req_rdata_o = r_rdata;
  assign mem_req_o   = r_mem_req;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mem_we_o    = r_we;
  assign mem_sel_o   = r_sel;
  assign grant_id_o  = r_grant;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Three arbiters share one stimulus stream: 4-way round-robin, 4-way fixed
// priority and 2-way round-robin (requestors 0..1 only), each against its own model.
module tb_core_mem_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = 4;
  localparam int NI    = 3;
  localparam int OBS_W = 109;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]      req_valid;
  logic [4*AW-1:0] req_addr;
  logic [4*DW-1:0] req_wdata;
  logic [3:0]      req_we;
  logic [4*SW-1:0] req_sel;
  logic            mem_ack;
  logic [DW-1:0]   mem_rdata;
  logic            flush;

  logic [3:0] ack_rr, ack_fp, msel_rr, msel_fp, msel_two;
  logic [1:0] ack_two, gid_rr, gid_fp;
  logic [0:0] gid_two;
  logic [DW-1:0] rdata_rr, rdata_fp, rdata_two, mwdata_rr, mwdata_fp, mwdata_two;
  logic [AW-1:0] maddr_rr, maddr_fp, maddr_two;
  logic mreq_rr, mreq_fp, mreq_two, mwe_rr, mwe_fp, mwe_two, busy_rr, busy_fp, busy_two;

  int n_checks = 0;
  int n_errors = 0;

  core_mem_arbiter #(.NUM_REQ(4), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0)) u_rr (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_we_i(req_we), .req_sel_i(req_sel),
    .req_ack_o(ack_rr), .req_rdata_o(rdata_rr), .mem_req_o(mreq_rr),
    .mem_addr_o(maddr_rr), .mem_wdata_o(mwdata_rr), .mem_we_o(mwe_rr),
    .mem_sel_o(msel_rr), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .flush_i(flush), .grant_id_o(gid_rr), .busy_o(busy_rr));

  core_mem_arbiter #(.NUM_REQ(4), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1)) u_fp (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_we_i(req_we), .req_sel_i(req_sel),
    .req_ack_o(ack_fp), .req_rdata_o(rdata_fp), .mem_req_o(mreq_fp),
    .mem_addr_o(maddr_fp), .mem_wdata_o(mwdata_fp), .mem_we_o(mwe_fp),
    .mem_sel_o(msel_fp), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .flush_i(flush), .grant_id_o(gid_fp), .busy_o(busy_fp));

  core_mem_arbiter #(.NUM_REQ(2), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0)) u_two (
    .clk(clk), .rst(rst), .req_valid_i(req_valid[1:0]), .req_addr_i(req_addr[2*AW-1:0]),
    .req_wdata_i(req_wdata[2*DW-1:0]), .req_we_i(req_we[1:0]), .req_sel_i(req_sel[2*SW-1:0]),
    .req_ack_o(ack_two), .req_rdata_o(rdata_two), .mem_req_o(mreq_two),
    .mem_addr_o(maddr_two), .mem_wdata_o(mwdata_two), .mem_we_o(mwe_two),
    .mem_sel_o(msel_two), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .flush_i(flush), .grant_id_o(gid_two), .busy_o(busy_two));

  logic [OBS_W-1:0] obs [NI];
  always_comb begin
    obs[0] = {ack_rr, rdata_rr, mreq_rr, maddr_rr, mwdata_rr, mwe_rr, msel_rr, gid_rr, busy_rr};
    obs[1] = {ack_fp, rdata_fp, mreq_fp, maddr_fp, mwdata_fp, mwe_fp, msel_fp, gid_fp, busy_fp};
    obs[2] = {2'b00, ack_two, rdata_two, mreq_two, maddr_two, mwdata_two, mwe_two, msel_two,
              1'b0, gid_two, busy_two};
  end

  // ---------------- behavioural model ----------------
  function automatic int f_nreq(input int k);
    return (k == 2) ? 2 : 4;
  endfunction

  function automatic bit f_fixed(input int k);
    return (k == 1);
  endfunction

  function automatic int f_pick(input logic [3:0] v, input int n, input int start);
    for (int i = 0; i < n; i++) begin
      int j;
      j = (start + i) % n;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  int         m_owner [NI];  // requestor being served, -1 when none
  bit         m_resp  [NI];  // ack pulse is showing this cycle
  int         m_ptr   [NI];
  int         e_gid   [NI];
  logic [3:0] e_ack   [NI];
  logic [DW-1:0] e_rdata [NI];
  logic [AW-1:0] e_addr  [NI];
  logic [DW-1:0] e_wdata [NI];
  logic       e_we    [NI];
  logic [3:0] e_sel   [NI];
  int         pick    [NI];

  always_comb begin
    for (int k = 0; k < NI; k++) begin
      pick[k] = f_pick(req_valid, f_nreq(k), f_fixed(k) ? 0 : m_ptr[k]);
    end
  end

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        m_owner[k] <= -1; m_resp[k] <= 1'b0; m_ptr[k] <= 0; e_gid[k] <= 0;
        e_ack[k] <= '0; e_rdata[k] <= '0; e_addr[k] <= '0; e_wdata[k] <= '0;
        e_we[k] <= 1'b0; e_sel[k] <= '0;
      end else if (m_resp[k]) begin
        m_resp[k]  <= 1'b0;
        m_owner[k] <= -1;
        e_ack[k]   <= '0;
      end else if (m_owner[k] >= 0) begin
        if (mem_ack) begin
          e_rdata[k] <= mem_rdata;
          e_ack[k]   <= 4'b0001 << m_owner[k];
          m_resp[k]  <= 1'b1;
        end
      end else if (!flush && pick[k] >= 0) begin
        m_owner[k] <= pick[k];
        e_gid[k]   <= pick[k];
        e_addr[k]  <= req_addr[pick[k]*AW +: AW];
        e_wdata[k] <= req_wdata[pick[k]*DW +: DW];
        e_we[k]    <= req_we[pick[k]];
        e_sel[k]   <= req_sel[pick[k]*SW +: SW];
        if (!f_fixed(k)) m_ptr[k] <= (pick[k] + 1) % f_nreq(k);
      end
    end
  end

  function automatic logic [OBS_W-1:0] f_exp(input int k);
    logic act, bsy;
    act = (m_owner[k] >= 0);
    bsy = act && !m_resp[k];
    return {e_ack[k], e_rdata[k], bsy, e_addr[k], e_wdata[k], e_we[k], e_sel[k],
            2'(e_gid[k]), act};
  endfunction

  // Every-cycle comparison of all outputs of all three instances.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NI; k++) begin
        n_checks++;
        if (obs[k] !== f_exp(k)) begin
          n_errors++;
          $display("FAIL model_inst%0d t=%0t actual=%h required=%h", k, $time, obs[k], f_exp(k));
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic we, input logic [SW-1:0] s);
    req_addr[k*AW +: AW]  = a;
    req_wdata[k*DW +: DW] = d;
    req_we[k]             = we;
    req_sel[k*SW +: SW]   = s;
  endtask

  // From an IDLE-cycle negedge: grant, 1-cycle ack, sample the ack pulse, back to IDLE.
  task automatic run_txn(input logic [DW-1:0] rd, output logic [3:0] a_rr,
                         output logic [3:0] a_fp, output logic [1:0] a_two);
    tick();
    mem_ack = 1'b1; mem_rdata = rd;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    a_rr = ack_rr; a_fp = ack_fp; a_two = ack_two;
    tick();
  endtask

  function automatic int f_idx(input logic [3:0] h);
    for (int i = 0; i < 4; i++) if (h == (4'b0001 << i)) return i;
    return -1;
  endfunction

  initial begin
    logic [3:0] a_rr, a_fp;
    logic [1:0] a_two;
    logic [3:0] rr_exp [3];
    int order_exp [8];
    int cnt [4];
    rr_exp = '{4'b0010, 4'b1000, 4'b0010};
    order_exp = '{0, 1, 2, 3, 0, 1, 2, 3};

    req_valid = '0; req_addr = '0; req_wdata = '0; req_we = '0; req_sel = '0;
    mem_ack = 1'b0; mem_rdata = '0; flush = 1'b0;
    repeat (2) tick();
    chk("reset_rr", obs[0], '0);
    chk("reset_fp", obs[1], '0);
    chk("reset_two", obs[2], '0);
    rst = 1'b0;
    tick();

    // single read with a 3-cycle downstream wait
    set_req(0, 32'h8000_0010, 32'h0, 1'b0, 4'hF);
    req_valid = 4'b0001;
    tick();
    chk("rd_req_t1", mreq_two, 1'b1);
    chk("rd_addr", maddr_two, 32'h8000_0010);
    tick();
    chk("rd_req_t2", mreq_two, 1'b1);
    tick();
    chk("rd_req_t3", mreq_two, 1'b1);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("rd_ack", ack_two, 2'b01);
    chk("rd_rdata", rdata_two, 32'hDEAD_BEEF);
    chk("rd_req_low", mreq_two, 1'b0);
    req_valid = 4'b0000;
    tick();
    chk("rd_ack_gone", ack_two, 2'b00);

    // fixed priority with requestors 1 and 3 both live, then 1 drops
    set_req(1, 32'h0000_1000, 32'h0, 1'b0, 4'hF);
    set_req(3, 32'h0000_3000, 32'h0, 1'b0, 4'h3);
    req_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      run_txn(32'h1000 + i, a_rr, a_fp, a_two);
      chk("fp_low_wins", a_fp, 4'b0010);
      chk("fp_rr_alt", a_rr, rr_exp[i]);
      chk("fp_two_only1", a_two, 2'b10);
    end
    req_valid = 4'b1000;
    run_txn(32'h3333, a_rr, a_fp, a_two);
    chk("fp_then3", a_fp, 4'b1000);
    chk("fp_rr_3", a_rr, 4'b1000);
    chk("fp_two_idle", a_two, 2'b00);
    req_valid = 4'b0000;
    tick();

    // flush raised mid-transaction; requestor 1 waits for it to clear
    set_req(0, 32'h0000_0040, 32'h0, 1'b0, 4'hF);
    set_req(1, 32'h0000_1040, 32'h0, 1'b0, 4'hF);
    req_valid = 4'b0001;
    tick();
    flush = 1'b1; req_valid = 4'b0011;
    tick();
    chk("fl_busy", busy_rr, 1'b1);
    mem_ack = 1'b1; mem_rdata = 32'h0F0F_0F0F;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("fl_ack0", ack_rr, 4'b0001);
    chk("fl_ack0_two", ack_two, 2'b01);
    req_valid = 4'b0010;
    tick();
    chk("fl_hold1", mreq_rr, 1'b0);
    tick();
    chk("fl_hold2", mreq_rr, 1'b0);
    chk("fl_idle", busy_rr, 1'b0);
    flush = 1'b0;
    tick();
    chk("fl_req_up", mreq_rr, 1'b1);
    chk("fl_gid", gid_rr, 2'd1);
    chk("fl_gid_two", gid_two, 1'b1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("fl_ack1", ack_rr, 4'b0010);
    req_valid = 4'b0000;
    tick();

    // request inputs change after grant
    set_req(0, 32'h0000_0100, 32'h0000_0011, 1'b1, 4'hF);
    req_valid = 4'b0001;
    tick();
    chk("chg_addr_t1", maddr_rr, 32'h100);
    tick();
    set_req(0, 32'h0000_0200, 32'h0000_0022, 1'b1, 4'hF);
    tick();
    chk("chg_addr_kept", maddr_rr, 32'h100);
    chk("chg_wdata_kept", mwdata_rr, 32'h11);
    chk("chg_we", mwe_rr, 1'b1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("chg_ack", ack_rr, 4'b0001);
    req_valid = 4'b0000;
    tick();

    // reset while BUSY, with everyone pending afterwards
    set_req(2, 32'h0000_2222, 32'h0, 1'b0, 4'hF);
    req_valid = 4'b0100;
    tick();
    chk("rst_pre_busy", busy_rr, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_rr", obs[0], '0);
    chk("rst_async_fp", obs[1], '0);
    req_valid = 4'b1111;
    tick();
    tick();
    rst = 1'b0;

    // round-robin fairness from p=0 with every requestor live
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int i = 0; i < 8; i++) begin
      run_txn(32'hA000 + i, a_rr, a_fp, a_two);
      chk("rr_order", f_idx(a_rr), order_exp[i]);
      chk("fair_fp", a_fp, 4'b0001);
      chk("fair_two", a_two, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (f_idx(a_rr) >= 0) cnt[f_idx(a_rr)]++;
    end
    for (int i = 0; i < 4; i++) chk("rr_count", cnt[i], 2);
    req_valid = 4'b0000;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Guard against a stalled stimulus sequence.
  initial begin
    #20000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
